// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipelined control unit for the 16-bit ISA. Decodes the ID-stage
//            instruction, carries control bits through ID/EX, EX/MEM and
//            MEM/WB, interlocks on load-use hazards, squashes flushed
//            instructions and sequences HLT (drain, then hold halted).
// Ports    : clk, rst            - clock, synchronous active-high reset
//            id_valid, id_instr  - ID-stage instruction and its valid flag
//            flush               - kill the ID instruction (taken branch)
//            rd1_addr, rd2_addr  - register-file read addresses (ID)
//            imm_size,branch_src - immediate size / next-PC source (ID)
//            stall               - hold PC and IF/ID, bubble into ID/EX
//            ex_alu_src          - EX-stage ALU B-operand select
//            mem_rd, mem_wr      - MEM-stage data-memory strobes
//            wb_we, wb_dst,
//            wb_dsrc             - WB-stage write enable, target, source
//            halt                - HLT has retired (sticky until rst)
// Revision : 1.0 - initial pipelined release
// ============================================================================
module pipe_ctrl #(
  parameter int REG_W     = 4,
  parameter int STALL_EN  = 1,
  parameter int HAZ_DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [15:0]      id_instr,
  input  logic             flush,
  output logic [REG_W-1:0] rd1_addr,
  output logic [REG_W-1:0] rd2_addr,
  output logic [1:0]       imm_size,
  output logic [1:0]       branch_src,
  output logic             stall,
  output logic             ex_alu_src,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             wb_we,
  output logic [REG_W-1:0] wb_dst,
  output logic [1:0]       wb_dsrc,
  output logic             halt
);

  // Opcodes
  localparam logic [3:0] c_OP_SLL = 4'b0100;
  localparam logic [3:0] c_OP_SRA = 4'b0101;
  localparam logic [3:0] c_OP_ROR = 4'b0110;
  localparam logic [3:0] c_OP_PAD = 4'b0111;
  localparam logic [3:0] c_OP_LW  = 4'b1000;
  localparam logic [3:0] c_OP_SW  = 4'b1001;
  localparam logic [3:0] c_OP_LHB = 4'b1010;
  localparam logic [3:0] c_OP_LLB = 4'b1011;
  localparam logic [3:0] c_OP_B   = 4'b1100;
  localparam logic [3:0] c_OP_BR  = 4'b1101;
  localparam logic [3:0] c_OP_PCS = 4'b1110;
  localparam logic [3:0] c_OP_HLT = 4'b1111;

  // Halt sequencer states
  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_DRAIN  = 2'd1;
  localparam logic [1:0] c_ST_HALTED = 2'd2;

  // Cycles from HLT acceptance until the youngest older instruction has
  // left WB (it sits in EX when HLT is in ID).
  localparam logic [1:0] c_DRAIN_CYC = 2'd2;

  // ---------------------------------------------------------------- decode
  logic [3:0]       w_op;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_rs;
  logic [REG_W-1:0] w_rt;
  logic             w_alu_src;
  logic             w_reg_write;
  logic [1:0]       w_dsrc;
  logic             w_uses1;
  logic             w_uses2;

  assign w_op = id_instr[15:12];
  assign w_rd = REG_W'(id_instr[11:8]);
  assign w_rs = REG_W'(id_instr[7:4]);
  assign w_rt = REG_W'(id_instr[3:0]);

  always_comb begin
    w_alu_src   = (w_op == c_OP_SLL) | (w_op == c_OP_SRA) | (w_op == c_OP_ROR) |
                  (w_op[3:2] == 2'b10);
    w_reg_write = ~w_op[3] | (w_op == c_OP_LW) | (w_op == c_OP_LHB) |
                  (w_op == c_OP_LLB) | (w_op == c_OP_PCS);

    if ((w_op == c_OP_SLL) || (w_op == c_OP_SRA) || (w_op == c_OP_ROR) ||
        (w_op == c_OP_LW) || (w_op == c_OP_SW)) begin
      imm_size = 2'b00;
    end else if ((w_op == c_OP_LHB) || (w_op == c_OP_LLB)) begin
      imm_size = 2'b01;
    end else begin
      imm_size = 2'b10;
    end

    if (w_op[3:2] == 2'b10) begin
      w_dsrc = 2'b00;
    end else if (w_op == c_OP_PCS) begin
      w_dsrc = 2'b10;
    end else begin
      w_dsrc = 2'b01;
    end

    w_uses1 = (w_op <= c_OP_LLB) | (w_op == c_OP_BR);
    w_uses2 = (w_op == 4'b0000) | (w_op == 4'b0001) | (w_op == 4'b0010) |
              (w_op == 4'b0011) | (w_op == c_OP_PAD) | (w_op == c_OP_SW);

    branch_src = 2'b00;
    if (id_valid) begin
      if (w_op == c_OP_B) begin
        branch_src = 2'b01;
      end else if (w_op == c_OP_BR) begin
        branch_src = 2'b10;
      end
    end
  end

  // LHB/LLB read-modify their own rd; SW stores the value held in rd.
  assign rd1_addr = ((w_op == c_OP_LHB) || (w_op == c_OP_LLB)) ? w_rd : w_rs;
  assign rd2_addr = (w_op == c_OP_SW) ? w_rd : w_rt;

  // --------------------------------------------------------- stage registers
  logic             ex_v_q,   ex_v_d;
  logic             ex_alu_q, ex_alu_d;
  logic             ex_mrd_q, ex_mrd_d;
  logic             ex_mwr_q, ex_mwr_d;
  logic             ex_we_q,  ex_we_d;
  logic [REG_W-1:0] ex_dst_q, ex_dst_d;
  logic [1:0]       ex_dsrc_q, ex_dsrc_d;

  logic             mem_v_q;
  logic             mem_mrd_q;
  logic             mem_mwr_q;
  logic             mem_we_q;
  logic [REG_W-1:0] mem_dst_q;
  logic [1:0]       mem_dsrc_q;

  logic             wb_v_q;
  logic             wb_we_q;
  logic [REG_W-1:0] wb_dst_q;
  logic [1:0]       wb_dsrc_q;

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt_q,   cnt_d;

  // ------------------------------------------------------------------ hazard
  logic w_run;
  logic w_haz_ex;
  logic w_haz_mem;
  logic w_hazard;
  logic w_hlt_go;
  logic w_issue;

  assign w_run    = (state_q == c_ST_RUN);
  // Only loads create an interlock; r0 is hard-wired and never a real source.
  assign w_haz_ex = ex_v_q & ex_mrd_q & (ex_dst_q != '0) &
                    ((w_uses1 & (ex_dst_q == rd1_addr)) |
                     (w_uses2 & (ex_dst_q == rd2_addr)));

  generate
    if (HAZ_DEPTH >= 2) begin : g_haz_mem
      // No MEM->EX forwarding path: a load in MEM still blocks its consumer.
      assign w_haz_mem = mem_v_q & mem_mrd_q & (mem_dst_q != '0) &
                         ((w_uses1 & (mem_dst_q == rd1_addr)) |
                          (w_uses2 & (mem_dst_q == rd2_addr)));
    end else begin : g_haz_ex_only
      assign w_haz_mem = 1'b0;
    end

    if (STALL_EN != 0) begin : g_stall_on
      assign w_hazard = w_run & id_valid & ~flush & (w_haz_ex | w_haz_mem);
    end else begin : g_stall_off
      assign w_hazard = 1'b0;
    end
  endgenerate

  assign w_hlt_go = w_run & id_valid & ~flush & ~w_hazard & (w_op == c_OP_HLT);
  assign w_issue  = w_run & id_valid & ~flush & ~w_hazard & (w_op != c_OP_HLT);
  assign stall    = ~w_run | w_hazard | w_hlt_go;

  // ------------------------------------------------------- next-state logic
  always_comb begin
    ex_v_d    = 1'b0;
    ex_alu_d  = 1'b0;
    ex_mrd_d  = 1'b0;
    ex_mwr_d  = 1'b0;
    ex_we_d   = 1'b0;
    ex_dst_d  = '0;
    ex_dsrc_d = 2'b00;
    if (w_issue) begin
      ex_v_d    = 1'b1;
      ex_alu_d  = w_alu_src;
      ex_mrd_d  = (w_op == c_OP_LW);
      ex_mwr_d  = (w_op == c_OP_SW);
      ex_we_d   = w_reg_write;
      ex_dst_d  = w_rd;
      ex_dsrc_d = w_dsrc;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_ST_RUN: begin
        if (w_hlt_go) begin
          state_d = c_ST_DRAIN;
          cnt_d   = c_DRAIN_CYC;
        end
      end
      c_ST_DRAIN: begin
        // Entering HALTED together with the counter reaching zero.
        if (cnt_q <= 2'd1) begin
          state_d = c_ST_HALTED;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      c_ST_HALTED: begin
        state_d = c_ST_HALTED;
      end
      default: begin
        state_d = c_ST_RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q     <= 1'b0;
      ex_alu_q   <= 1'b0;
      ex_mrd_q   <= 1'b0;
      ex_mwr_q   <= 1'b0;
      ex_we_q    <= 1'b0;
      ex_dst_q   <= '0;
      ex_dsrc_q  <= 2'b00;
      mem_v_q    <= 1'b0;
      mem_mrd_q  <= 1'b0;
      mem_mwr_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_dst_q  <= '0;
      mem_dsrc_q <= 2'b00;
      wb_v_q     <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_dst_q   <= '0;
      wb_dsrc_q  <= 2'b00;
      state_q    <= c_ST_RUN;
      cnt_q      <= 2'd0;
    end else begin
      ex_v_q    <= ex_v_d;
      ex_alu_q  <= ex_alu_d;
      ex_mrd_q  <= ex_mrd_d;
      ex_mwr_q  <= ex_mwr_d;
      ex_we_q   <= ex_we_d;
      ex_dst_q  <= ex_dst_d;
      ex_dsrc_q <= ex_dsrc_d;
      if (state_q == c_ST_HALTED) begin
        mem_v_q    <= 1'b0;
        mem_mrd_q  <= 1'b0;
        mem_mwr_q  <= 1'b0;
        mem_we_q   <= 1'b0;
        mem_dst_q  <= '0;
        mem_dsrc_q <= 2'b00;
        wb_v_q     <= 1'b0;
        wb_we_q    <= 1'b0;
        wb_dst_q   <= '0;
        wb_dsrc_q  <= 2'b00;
      end else begin
        mem_v_q    <= ex_v_q;
        mem_mrd_q  <= ex_mrd_q;
        mem_mwr_q  <= ex_mwr_q;
        mem_we_q   <= ex_we_q;
        mem_dst_q  <= ex_dst_q;
        mem_dsrc_q <= ex_dsrc_q;
        wb_v_q     <= mem_v_q;
        wb_we_q    <= mem_we_q;
        wb_dst_q   <= mem_dst_q;
        wb_dsrc_q  <= mem_dsrc_q;
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ----------------------------------------------------------------- outputs
  assign ex_alu_src = ex_v_q & ex_alu_q;
  assign mem_rd     = mem_v_q & mem_mrd_q;
  assign mem_wr     = mem_v_q & mem_mwr_q;
  assign wb_we      = wb_v_q & wb_we_q;
  assign wb_dst     = wb_v_q ? wb_dst_q : '0;
  assign wb_dsrc    = wb_v_q ? wb_dsrc_q : 2'b00;
  assign halt       = (state_q == c_ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl. Directed scenarios followed
//            by randomized traffic, all compared against a behavioural model
//            that tracks in-flight instructions by age.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int REG_W     = 4;
  localparam int STALL_EN  = 1;
  localparam int HAZ_DEPTH = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [15:0]      id_instr;
  logic             flush;
  logic [REG_W-1:0] rd1_addr;
  logic [REG_W-1:0] rd2_addr;
  logic [1:0]       imm_size;
  logic [1:0]       branch_src;
  logic             stall;
  logic             ex_alu_src;
  logic             mem_rd;
  logic             mem_wr;
  logic             wb_we;
  logic [REG_W-1:0] wb_dst;
  logic [1:0]       wb_dsrc;
  logic             halt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .REG_W    (REG_W),
    .STALL_EN (STALL_EN),
    .HAZ_DEPTH(HAZ_DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .flush     (flush),
    .rd1_addr  (rd1_addr),
    .rd2_addr  (rd2_addr),
    .imm_size  (imm_size),
    .branch_src(branch_src),
    .stall     (stall),
    .ex_alu_src(ex_alu_src),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .wb_we     (wb_we),
    .wb_dst    (wb_dst),
    .wb_dsrc   (wb_dsrc),
    .halt      (halt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------- model
  // Per-opcode control table: {alu_src, reg_write, mem_rd, mem_wr, imm[1:0], dsrc[1:0]}
  function automatic logic [7:0] ctl_of(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: ctl_of = 8'b0_1_0_0_10_01; // ADD SUB XOR RED PADDSB
      4'h4, 4'h5, 4'h6:             ctl_of = 8'b1_1_0_0_00_01; // SLL SRA ROR
      4'h8:                         ctl_of = 8'b1_1_1_0_00_00; // LW
      4'h9:                         ctl_of = 8'b1_0_0_1_00_00; // SW
      4'hA, 4'hB:                   ctl_of = 8'b1_1_0_0_01_00; // LHB LLB
      4'hE:                         ctl_of = 8'b0_1_0_0_10_10; // PCS
      default:                      ctl_of = 8'b0_0_0_0_10_01; // B BR HLT
    endcase
  endfunction

  function automatic logic [3:0] src1_of(input logic [15:0] ins);
    return (ins[15:12] == 4'hA || ins[15:12] == 4'hB) ? ins[11:8] : ins[7:4];
  endfunction

  function automatic logic [3:0] src2_of(input logic [15:0] ins);
    return (ins[15:12] == 4'h9) ? ins[11:8] : ins[3:0];
  endfunction

  function automatic bit reads_reg(input logic [15:0] ins, input logic [3:0] r);
    logic [3:0] op;
    bit u1, u2;
    op = ins[15:12];
    u1 = (op <= 4'hB) || (op == 4'hD);
    u2 = (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'h3) ||
         (op == 4'h7) || (op == 4'h9);
    return (u1 && src1_of(ins) == r) || (u2 && src2_of(ins) == r);
  endfunction

  // slot = {valid, instr}
  function automatic bit load_hit(input logic [16:0] slot, input logic [15:0] ins);
    return slot[16] && slot[15:12] == 4'h8 && slot[11:8] != 4'h0 &&
           reads_reg(ins, slot[11:8]);
  endfunction

  logic [16:0] pm [3];     // 0 = EX, 1 = MEM, 2 = WB
  int          mstate = 0; // 0 run, 1 draining, 2 halted
  int          age    = 0; // cycles since HLT accepted
  bit          m_hz, m_go;
  logic        obs_stall, obs_halt;

  task automatic cycle(input logic r, input logic v, input logic [15:0] ins, input logic fl);
    logic [3:0] op;
    logic [7:0] c0, c1, c2;
    logic [1:0] e_br;
    bit         e_stall;
    rst = r; id_valid = v; id_instr = ins; flush = fl;
    @(negedge clk);
    op   = ins[15:12];
    m_hz = (STALL_EN != 0) && mstate == 0 && v && !fl &&
           (load_hit(pm[0], ins) || (HAZ_DEPTH == 2 && load_hit(pm[1], ins)));
    m_go = mstate == 0 && v && !fl && !m_hz && op == 4'hF;
    e_stall = (mstate != 0) || m_hz || m_go;
    e_br = !v ? 2'b00 : (op == 4'hC) ? 2'b01 : (op == 4'hD) ? 2'b10 : 2'b00;
    c0 = ctl_of(pm[0][15:12]);
    c1 = ctl_of(pm[1][15:12]);
    c2 = ctl_of(pm[2][15:12]);
    obs_stall = stall;
    obs_halt  = halt;
    check("rd1_addr",   16'(rd1_addr),   16'(src1_of(ins)));
    check("rd2_addr",   16'(rd2_addr),   16'(src2_of(ins)));
    check("imm_size",   16'(imm_size),   16'(ctl_of(op) >> 2 & 8'h3));
    check("branch_src", 16'(branch_src), 16'(e_br));
    check("stall",      16'(stall),      16'(e_stall));
    check("ex_alu_src", 16'(ex_alu_src), 16'(pm[0][16] & c0[7]));
    check("mem_rd",     16'(mem_rd),     16'(pm[1][16] & c1[5]));
    check("mem_wr",     16'(mem_wr),     16'(pm[1][16] & c1[4]));
    check("wb_we",      16'(wb_we),      16'(pm[2][16] & c2[6]));
    check("wb_dst",     16'(wb_dst),     pm[2][16] ? 16'(pm[2][11:8]) : 16'h0);
    check("wb_dsrc",    16'(wb_dsrc),    pm[2][16] ? 16'(c2[1:0]) : 16'h0);
    check("halt",       16'(halt),       16'(mstate == 2));
    @(posedge clk);
    #1;
    if (r) begin
      pm[0] = '0; pm[1] = '0; pm[2] = '0;
      mstate = 0; age = 0;
    end else begin
      pm[2] = pm[1];
      pm[1] = pm[0];
      pm[0] = (mstate == 0 && v && !fl && !m_hz && op != 4'hF) ? {1'b1, ins} : 17'h0;
      if (m_go) begin
        mstate = 1; age = 1;
      end else if (mstate == 1) begin
        age++;
        if (age == 3) mstate = 2;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
    return {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
  endfunction

  // --------------------------------------------------------------- stimulus
  initial begin
    int          n;
    logic        hv;
    logic [15:0] hi;
    logic        r, fl;

    pm[0] = '0; pm[1] = '0; pm[2] = '0;
    rst = 1'b1; id_valid = 1'b0; id_instr = 16'h0000; flush = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);   // reset state
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);

    // T1: single ADD retires three cycles later
    cycle(1'b0, 1'b1, 16'h0312, 1'b0);
    idle(5);

    // T2: load-use stall on rs
    cycle(1'b0, 1'b1, 16'h8410, 1'b0);
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 16'h0542, 1'b0);
      if (obs_stall) n++;
    end while (obs_stall && n < 5);
    check("t2_stall_len", 16'(n), 16'(HAZ_DEPTH));
    idle(4);

    // T3: r0 exempt; SW data register matches via rd2
    cycle(1'b0, 1'b1, 16'h8010, 1'b0);
    cycle(1'b0, 1'b1, 16'h0502, 1'b0);
    check("t3_r0_nostall", 16'(obs_stall), 16'h0);
    cycle(1'b0, 1'b1, 16'h8410, 1'b0);
    cycle(1'b0, 1'b1, 16'h9410, 1'b0);
    check("t3_sw_stall", 16'(obs_stall), 16'h1);
    cycle(1'b0, 1'b1, 16'h9410, 1'b0);
    idle(4);

    // T4: flushed HLT does not halt; flush beats hazard
    cycle(1'b0, 1'b1, 16'hF000, 1'b1);
    idle(4);
    check("t4_no_halt", 16'(obs_halt), 16'h0);
    cycle(1'b0, 1'b1, 16'h8410, 1'b0);
    cycle(1'b0, 1'b1, 16'h0542, 1'b1);
    check("t4_flush_stall", 16'(obs_stall), 16'h0);
    idle(4);

    // T5: ADD, SUB, HLT -> drain then halt; reset clears
    cycle(1'b0, 1'b1, 16'h0312, 1'b0);
    cycle(1'b0, 1'b1, 16'h1645, 1'b0);
    cycle(1'b0, 1'b1, 16'hF000, 1'b0);
    check("t5_hlt_stall", 16'(obs_stall), 16'h1);
    idle(3);
    check("t5_halt", 16'(obs_halt), 16'h1);
    idle(2);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    idle(1);
    check("t5_rst_halt", 16'(obs_halt), 16'h0);

    // Reset in the middle of a drain returns to normal operation
    cycle(1'b0, 1'b1, 16'hF000, 1'b0);
    idle(1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 1'b1, 16'h0312, 1'b0);
    idle(4);

    // Randomized traffic; a stalled instruction is re-presented
    hv = 1'b0; hi = 16'h0000;
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 99) == 0) || (mstate == 2 && $urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      if (!m_hz || i == 0) begin
        hv = ($urandom_range(0, 3) != 0);
        hi = rand_instr();
      end
      cycle(r, hv, hi, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
